led_frame_sequencer: RTL and testbench

- Upstream stage of the LED array pixel writer. Holds a COLS-byte column RAM written by the host.
- Whenever the RAM, brightness or display enable changes, streams one full refresh frame into the pixel writer over its valid/pos/value/busy handshake.
- Frame format: mode command, one addressed write per column, then display-control command.

---
 rtl/led_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
// LED frame sequencer: host-written column RAM streamed to the
// pixel writer as mode / per-column / display-control transfers.
module led_frame_sequencer #(
    parameter int         COLS        = 16,
    parameter int         ACK_TIMEOUT = 8,
    parameter logic [7:0] MODE_CMD    = 8'h44,
    parameter logic [7:0] ADDR_CMD    = 8'hC0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] brightness,
    input  logic       display_on,
    input  logic       refresh,
    input  logic       busy,
    output logic       valid,
    output logic [7:0] pos,
    output logic [7:0] value,
    output logic       frame_busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, MODE, COL, CTRL} state_t;
    typedef enum logic [1:0] {REQ, ACK, DONE} hs_t;

    state_t      state, state_d;
    hs_t         hs, hs_d;
    logic [3:0]  col, col_d;
    logic [15:0] tmr, tmr_d;
    logic [7:0]  ram [16];
    logic [3:0]  ctrl_q;
    logic        dirty;
    logic        start;
    logic        wr_ok;
    logic        set_evt;
    logic        valid_d;
    logic [7:0]  pos_d;
    logic [7:0]  value_d;
    logic        fbusy_d;
    logic        fdone_d;
    logic [7:0]  word_pos;
    logic [7:0]  word_val;

    assign wr_ok   = wr_en && ({1'b0, wr_addr} < 5'(COLS));
    assign set_evt = wr_ok || refresh
                   || ({display_on, brightness} != ctrl_q);

    // Word for the current top state; RAM read is combinational so a
    // same-cycle host write is stored but the old byte goes out.
    always_comb begin
        word_pos = 8'hFF;
        word_val = MODE_CMD;
        unique case (state)
            COL: begin
                word_pos = ADDR_CMD | {4'b0000, col};
                word_val = ram[col];
            end
            CTRL:    word_val = {4'b1000, display_on, brightness};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        hs_d    = hs;
        col_d   = col;
        tmr_d   = tmr;
        valid_d = 1'b0;
        pos_d   = pos;
        value_d = value;
        fbusy_d = frame_busy;
        fdone_d = 1'b0;
        start   = 1'b0;
        if (state == IDLE) begin
            if (dirty && !busy) begin
                state_d = MODE;
                hs_d    = REQ;
                col_d   = '0;
                fbusy_d = 1'b1;
                start   = 1'b1;
            end
        end else begin
            unique case (hs)
                REQ: begin
                    if (!busy) begin
                        valid_d = 1'b1;
                        pos_d   = word_pos;
                        value_d = word_val;
                        tmr_d   = '0;
                        hs_d    = ACK;
                    end
                end
                ACK: begin
                    if (busy) begin
                        hs_d = DONE;
                    end else if (tmr == 16'(ACK_TIMEOUT - 1)) begin
                        hs_d = REQ;
                    end else begin
                        tmr_d = tmr + 16'd1;
                    end
                end
                default: begin
                    if (!busy) begin
                        hs_d = REQ;
                        unique case (state)
                            MODE: begin
                                state_d = COL;
                                col_d   = '0;
                            end
                            COL: begin
                                if (col == 4'(COLS - 1)) begin
                                    state_d = CTRL;
                                end else begin
                                    col_d = col + 4'd1;
                                end
                            end
                            default: begin
                                state_d = IDLE;
                                fbusy_d = 1'b0;
                                fdone_d = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hs         <= REQ;
            col        <= '0;
            tmr        <= '0;
            dirty      <= 1'b1;
            ctrl_q     <= {display_on, brightness};
            valid      <= 1'b0;
            pos        <= 8'hFF;
            value      <= 8'h00;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
        end else begin
            state      <= state_d;
            hs         <= hs_d;
            col        <= col_d;
            tmr        <= tmr_d;
            ctrl_q     <= {display_on, brightness};
            valid      <= valid_d;
            pos        <= pos_d;
            value      <= value_d;
            frame_busy <= fbusy_d;
            frame_done <= fdone_d;
            // Events during the start cycle survive so one more frame follows.
            dirty      <= start ? set_evt : (dirty || set_evt);
            if (wr_ok) ram[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: a 16-column instance with a
// slow busy model and a 12-column instance for address bounds.
module tb_led_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, wr_en, display_on, refresh, valid;
    logic       frame_busy, frame_done;
    logic       busy = 1'b0;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, pos, value;
    logic [2:0] brightness;

    logic       rb, wr_en_b, display_on_b, refresh_b, valid_b;
    logic       frame_busy_b, frame_done_b;
    logic       busy_b = 1'b0;
    logic [3:0] wr_addr_b;
    logic [7:0] wr_data_b, pos_b, value_b;
    logic [2:0] brightness_b;

    led_frame_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .brightness(brightness),
        .display_on(display_on), .refresh(refresh), .busy(busy),
        .valid(valid), .pos(pos), .value(value),
        .frame_busy(frame_busy), .frame_done(frame_done)
    );

    led_frame_sequencer #(.COLS(12)) dut_b (
        .clk(clk), .reset(rb), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .brightness(brightness_b),
        .display_on(display_on_b), .refresh(refresh_b), .busy(busy_b),
        .valid(valid_b), .pos(pos_b), .value(value_b),
        .frame_busy(frame_busy_b), .frame_done(frame_done_b)
    );

    // Pixel writer model: busy rises the cycle after valid, held 20 cycles.
    int cnt = 0, ign_n = 0, ign_cnt = 0;
    always @(posedge clk) begin
        if (valid && ign_cnt < ign_n) begin
            ign_cnt <= ign_cnt + 1;
        end else if (valid) begin
            busy <= 1'b1;
            cnt  <= 20;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else begin
            cnt  <= 0;
            busy <= 1'b0;
        end
    end

    int cnt_b = 0;
    always @(posedge clk) begin
        if (valid_b) begin
            busy_b <= 1'b1;
            cnt_b  <= 3;
        end else if (cnt_b > 1) begin
            cnt_b <= cnt_b - 1;
        end else begin
            cnt_b  <= 0;
            busy_b <= 1'b0;
        end
    end

    logic [7:0]  lp[$], lv[$], lpb[$], lvb[$];
    int unsigned lt[$];
    int done_cnt = 0, done_b = 0, viol = 0, viol_b = 0;
    always @(negedge clk) begin
        if (valid) begin
            lp.push_back(pos);
            lv.push_back(value);
            lt.push_back(cyc);
        end
        if (valid && busy) viol <= viol + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (valid_b) begin
            lpb.push_back(pos_b);
            lvb.push_back(value_b);
        end
        if (valid_b && busy_b) viol_b <= viol_b + 1;
        if (frame_done_b) done_b <= done_b + 1;
    end

    task automatic pulse_refresh();
        @(negedge clk) refresh = 1'b1;
        @(negedge clk) refresh = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ep, ev;
        reset = 1'b1;
        rb = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++; $display("FAIL rst_valid got %b want 0", valid);
        end
        checks++;
        if (pos !== 8'hFF) begin
            failures++; $display("FAIL rst_pos got %h want ff", pos);
        end
        checks++;
        if (value !== 8'h00) begin
            failures++; $display("FAIL rst_value got %h want 00", value);
        end
        checks++;
        if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_frame got %b%b want 00", frame_busy, frame_done);
        end
        reset = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 3000 && done_cnt < 1; i++) @(negedge clk);
        checks++;
        if (done_cnt < 1) begin
            failures++; $display("FAIL rst_frame_timeout done=%0d want 1", done_cnt);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (lp.size() != 18 || done_cnt != 1) begin
            failures++;
            $display("FAIL rst_count got %0d/%0d want 18/1", lp.size(), done_cnt);
        end
        for (int i = 0; i < 18; i++) begin
            ep = (i == 0 || i == 17) ? 8'hFF : 8'hC0 + 8'(i - 1);
            ev = (i == 0) ? 8'h44 : (i == 17) ? 8'h80 : 8'h00;
            checks++;
            if (lp[i] !== ep || lv[i] !== ev) begin
                failures++;
                $display("FAIL rst_xfer%0d got %h/%h want %h/%h", i, lp[i], lv[i], ep, ev);
            end
        end
        checks++;
        if (frame_busy !== 1'b0) begin
            failures++; $display("FAIL rst_fbusy_after got 1 want 0");
        end
    endtask

    task automatic test_write_ctrl();
        int base = lp.size();
        int d0 = done_cnt;
        logic [7:0] ep, ev;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        brightness = 3'd5; display_on = 1'b1;
        @(negedge clk) wr_en = 1'b0;
        for (int i = 0; i < 3000 && done_cnt < d0 + 1; i++) @(negedge clk);
        repeat (60) @(negedge clk);
        checks++;
        if (lp.size() - base != 18 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL wr_count got %0d/%0d want 18/1", lp.size() - base, done_cnt - d0);
        end
        for (int i = 0; i < 18; i++) begin
            ep = (i == 0 || i == 17) ? 8'hFF : 8'hC0 + 8'(i - 1);
            ev = (i == 0) ? 8'h44 : (i == 17) ? 8'h8D : (i == 4) ? 8'hA5 : 8'h00;
            checks++;
            if (lp[base+i] !== ep || lv[base+i] !== ev) begin
                failures++;
                $display("FAIL wr_xfer%0d got %h/%h want %h/%h",
                         i, lp[base+i], lv[base+i], ep, ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = lp.size();
        int d0 = done_cnt;
        int k;
        logic [7:0] ep, ev;
        pulse_refresh();
        for (int i = 0; i < 2000 && lp.size() <= base + 3; i++) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
        @(negedge clk) wr_en = 1'b0;
        for (int i = 0; i < 6000 && done_cnt < d0 + 2; i++) @(negedge clk);
        repeat (60) @(negedge clk);
        checks++;
        if (lp.size() - base != 36 || done_cnt != d0 + 2) begin
            failures++;
            $display("FAIL b2b_count got %0d/%0d want 36/2", lp.size() - base, done_cnt - d0);
        end
        for (int i = 0; i < 36; i++) begin
            k = i % 18;
            ep = (k == 0 || k == 17) ? 8'hFF : 8'hC0 + 8'(k - 1);
            ev = (k == 0) ? 8'h44 : (k == 17) ? 8'h8D :
                 (k == 4) ? 8'hA5 : (k == 8) ? 8'h3C : 8'h00;
            checks++;
            if (lp[base+i] !== ep || lv[base+i] !== ev) begin
                failures++;
                $display("FAIL b2b_xfer%0d got %h/%h want %h/%h",
                         i, lp[base+i], lv[base+i], ep, ev);
            end
        end
    endtask

    task automatic test_timeout();
        int base = lp.size();
        int d0 = done_cnt;
        logic [7:0] ep, ev;
        ign_n = ign_cnt + 1;
        pulse_refresh();
        for (int i = 0; i < 3000 && done_cnt < d0 + 1; i++) @(negedge clk);
        repeat (60) @(negedge clk);
        checks++;
        if (lp.size() - base != 19) begin
            failures++; $display("FAIL to_count got %0d want 19", lp.size() - base);
        end
        checks++;
        if (lp[base+1] !== 8'hFF || lv[base+1] !== 8'h44) begin
            failures++;
            $display("FAIL to_reissue got %h/%h want ff/44", lp[base+1], lv[base+1]);
        end
        // 8 ACK cycles with busy low, then one REQ cycle before reissue.
        checks++;
        if (lt[base+1] - lt[base] != 9) begin
            failures++; $display("FAIL to_gap got %0d want 9", lt[base+1] - lt[base]);
        end
        for (int i = 1; i < 19; i++) begin
            ep = (i == 1 || i == 18) ? 8'hFF : 8'hC0 + 8'(i - 2);
            ev = (i == 1) ? 8'h44 : (i == 18) ? 8'h8D :
                 (i == 5) ? 8'hA5 : (i == 9) ? 8'h3C : 8'h00;
            checks++;
            if (lp[base+i] !== ep || lv[base+i] !== ev) begin
                failures++;
                $display("FAIL to_xfer%0d got %h/%h want %h/%h",
                         i, lp[base+i], lv[base+i], ep, ev);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base = lp.size();
        int base2;
        int d0 = done_cnt;
        logic [7:0] ep, ev;
        pulse_refresh();
        for (int i = 0; i < 3000 && lp.size() <= base + 10; i++) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || pos !== 8'hFF || value !== 8'h00
            || frame_busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got v=%b p=%h d=%h fb=%b fd=%b want 0/ff/00/0/0",
                     valid, pos, value, frame_busy, frame_done);
        end
        @(negedge clk) reset = 1'b0;
        base2 = lp.size();
        for (int i = 0; i < 3000 && done_cnt < d0 + 1; i++) @(negedge clk);
        repeat (60) @(negedge clk);
        checks++;
        if (lp.size() - base2 != 18 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL mid_count got %0d/%0d want 18/1", lp.size() - base2, done_cnt - d0);
        end
        for (int i = 0; i < 18; i++) begin
            ep = (i == 0 || i == 17) ? 8'hFF : 8'hC0 + 8'(i - 1);
            ev = (i == 0) ? 8'h44 : (i == 17) ? 8'h8D : 8'h00;
            checks++;
            if (lp[base2+i] !== ep || lv[base2+i] !== ev) begin
                failures++;
                $display("FAIL mid_xfer%0d got %h/%h want %h/%h",
                         i, lp[base2+i], lv[base2+i], ep, ev);
            end
        end
    endtask

    task automatic test_cols12();
        int base;
        int d0;
        checks++;
        if (done_b != 1 || lpb.size() != 14) begin
            failures++;
            $display("FAIL c12_first got %0d/%0d want 1/14", done_b, lpb.size());
        end
        checks++;
        if (lpb[12] !== 8'hCB || lpb[13] !== 8'hFF || lvb[13] !== 8'h80) begin
            failures++;
            $display("FAIL c12_tail got %h %h/%h want cb ff/80", lpb[12], lpb[13], lvb[13]);
        end
        base = lpb.size();
        d0 = done_b;
        @(negedge clk);
        wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_data_b = 8'hFF;
        @(negedge clk) wr_en_b = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (lpb.size() != base || frame_busy_b !== 1'b0 || done_b != d0) begin
            failures++;
            $display("FAIL c12_oob got %0d xfers fb=%b want 0 xfers fb=0",
                     lpb.size() - base, frame_busy_b);
        end
        @(negedge clk);
        wr_en_b = 1'b1; wr_addr_b = 4'd11; wr_data_b = 8'h5A;
        @(negedge clk) wr_en_b = 1'b0;
        for (int i = 0; i < 1000 && done_b < d0 + 1; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (lpb.size() - base != 14) begin
            failures++; $display("FAIL c12_count got %0d want 14", lpb.size() - base);
        end
        checks++;
        if (lpb[base+12] !== 8'hCB || lvb[base+12] !== 8'h5A) begin
            failures++;
            $display("FAIL c12_last got %h/%h want cb/5a", lpb[base+12], lvb[base+12]);
        end
        for (int i = 1; i < 12; i++) begin
            checks++;
            if (lvb[base+i] !== 8'h00) begin
                failures++; $display("FAIL c12_col%0d got %h want 00", i - 1, lvb[base+i]);
            end
        end
    endtask

    task automatic test_no_valid_while_busy();
        checks++;
        if (viol != 0 || viol_b != 0) begin
            failures++;
            $display("FAIL valid_busy got %0d/%0d want 0/0", viol, viol_b);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        brightness = '0; display_on = 1'b0; refresh = 1'b0;
        rb = 1'b1; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        brightness_b = '0; display_on_b = 1'b0; refresh_b = 1'b0;
        test_reset();
        test_write_ctrl();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_cols12();
        test_no_valid_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
